// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op
// encodings, FSM state encoding, default width and operand-signedness helpers.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Operand a is treated as two's complement for these ops. MUL is handled
  // as unsigned because its low half does not depend on signedness.
  function automatic logic a_is_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the integer pipeline (master) and the
// multiply/divide unit (slave).
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            we_out;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, we_out
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, we_out
  );
endinterface

// File: rtl/muldiv_core.sv
// Iteration datapath: one shift-add multiply step or one restoring-divide
// step per cycle, operating on unsigned magnitudes.
//  multiply: {hi,lo} ends as the 2*XLEN product of mag_a * mag_b
//  divide:   lo ends as quotient, hi as remainder of mag_a / mag_b
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, d_q;
  logic            div_mode_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff, div_hi, div_lo;

  // Next-step candidates for both algorithms
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    mul_hi    = mul_sum[XLEN:1];
    mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, d_q});
    // The true difference is below d_q whenever it is taken, so XLEN bits suffice
    div_diff  = div_shift[XLEN-1:0] - d_q;
    div_hi    = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_lo    = {lo_q[XLEN-2:0], div_ge};
  end

  // Working registers: loaded on accept, advanced once per busy cycle
  always_ff @(posedge CLK) begin
    if (load) begin
      hi_q       <= '0;
      lo_q       <= mag_a;
      d_q        <= mag_b;
      div_mode_q <= is_div;
    end else if (step) begin
      hi_q <= div_mode_q ? div_hi : mul_hi;
      lo_q <= div_mode_q ? div_lo : mul_lo;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit feeding the register-file write port.
// Owns the IDLE/BUSY/DONE control, operand latching, sign fix-up and the
// divide-by-zero / signed-overflow short-circuits.
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiply
// with a single-cycle 33x33 signed product (divide stays iterative).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic     CLK,
  input  logic     reset,
  muldiv_if.slave  bus
);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             core_load, core_step;

  // Request decode, valid only while IDLE with start high
  op_e              op_in;
  logic             sa_in, sb_in, is_div_in;
  logic             div_zero, div_ovf, short_in, fast_in;
  logic [XLEN-1:0]  mag_a_in, mag_b_in, sc_val_in;

  // Latched request
  op_e              op_q;
  logic [4:0]       rd_q;
  logic             neg_q, sa_q, sc_q;
  logic [XLEN-1:0]  sc_val_q;

  logic [XLEN-1:0]  core_hi, core_lo;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]  final_res;

  assign op_in     = op_e'(bus.op);
  assign sa_in     = a_is_signed(op_in) & bus.rs1_val[XLEN-1];
  assign sb_in     = b_is_signed(op_in) & bus.rs2_val[XLEN-1];
  assign mag_a_in  = cond_neg(bus.rs1_val, sa_in);
  assign mag_b_in  = cond_neg(bus.rs2_val, sb_in);
  assign is_div_in = op_in[2];
  assign div_zero  = is_div_in && (bus.rs2_val == '0);
  assign div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                     (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rs2_val == '1);
  assign short_in  = div_zero | div_ovf;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_in = ~is_div_in;
`else
  assign fast_in = 1'b0;
`endif

  // Short-circuit results: all-ones / dividend for x/0, MIN / 0 for MIN/-1
  always_comb begin
    sc_val_in = '0;
    if (div_zero) begin
      sc_val_in = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : bus.rs1_val;
    end else if (div_ovf) begin
      sc_val_in = (op_in == OP_DIV) ? bus.rs1_val : '0;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          core_load = 1'b1;
          state_d   = (short_in || fast_in) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        core_step = 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Iteration counter
  always_ff @(posedge CLK) begin
    if (reset)          cnt_q <= '0;
    else if (core_load) cnt_q <= '0;
    else if (core_step) cnt_q <= cnt_q + 1'b1;
  end

  // Request latch; only consumed in DONE so it carries no reset
  always_ff @(posedge CLK) begin
    if (core_load) begin
      op_q     <= op_in;
      rd_q     <= bus.rd_in;
      neg_q    <= sa_in ^ sb_in;
      sa_q     <= sa_in;
      sc_q     <= short_in;
      sc_val_q <= sc_val_in;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .CLK    (CLK),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div_in),
    .mag_a  (mag_a_in),
    .mag_b  (mag_b_in),
    .hi     (core_hi),
    .lo     (core_lo)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN-1:0]          a_q, b_q;
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;

  // Raw operands kept for the combinational product
  always_ff @(posedge CLK) begin
    if (core_load) begin
      a_q <= bus.rs1_val;
      b_q <= bus.rs2_val;
    end
  end

  assign fast_a    = signed'({a_is_signed(op_q) & a_q[XLEN-1], a_q});
  assign fast_b    = signed'({b_is_signed(op_q) & b_q[XLEN-1], b_q});
  assign fast_prod = (2*XLEN)'(fast_a * fast_b);
  assign mul_prod  = fast_prod;
`else
  assign mul_prod  = cond_neg_wide({core_hi, core_lo}, neg_q);
`endif

  // Result selection and sign fix-up; remainder takes the dividend's sign
  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:                       final_res = mul_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = cond_neg(core_lo, neg_q);
      OP_REM, OP_REMU:              final_res = cond_neg(core_hi, sa_q);
      default:                      final_res = '0;
    endcase
    if (sc_q) final_res = sc_val_q;
  end

  // Write-port outputs: one-cycle done/we pulse, result held until next completion
  always_ff @(posedge CLK) begin
    if (reset) begin
      bus.done   <= 1'b0;
      bus.we_out <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
    end else begin
      bus.done   <= (state_q == S_DONE);
      bus.we_out <= (state_q == S_DONE) && (rd_q != 5'd0);
      if (state_q == S_DONE) begin
        bus.result <= final_res;
        bus.rd_out <= rd_q;
      end
    end
  end

  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Issue one request (caller is at a falling edge) and wait for done.
  // poke > 0 drives a competing start with other operands lat=poke cycles in.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int poke,
                       output logic [31:0] res, output logic [4:0] rdo,
                       output logic weo, output int lat);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    @(posedge CLK);
    #1;
    bus.start   = 1'b0;
    bus.op      = 3'd4;
    bus.rs1_val = 32'hDEAD_BEEF;
    bus.rs2_val = 32'h0000_0000;
    bus.rd_in   = 5'd31;
    lat = 0;
    res = 'x; rdo = 'x; weo = 1'bx;
    for (int i = 1; i <= 100; i++) begin
      @(posedge CLK);
      #1 bus.start = 1'b0;
      @(negedge CLK);
      if (bus.done === 1'b1) begin
        lat = i;
        res = bus.result;
        rdo = bus.rd_out;
        weo = bus.we_out;
        break;
      end
      if (i == poke) begin
        bus.start   = 1'b1;
        bus.op      = 3'd0;
        bus.rs1_val = 32'h0000_0003;
        bus.rs2_val = 32'h0000_0005;
        bus.rd_in   = 5'd9;
      end
    end
    if (lat == 0) lat = -1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.we_out !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.we_out); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.rd_out); end
    reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_mul;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, r, rd, we, lat);
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
    checks++; if (rd !== 5'd5) begin errors++; $display("FAIL mul_rd got=%0d exp=5", rd); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL mul_we got=%b exp=1", we); end
    checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); end
    @(negedge CLK);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_width got=%b exp=0", bus.done); end
    checks++; if (bus.we_out !== 1'b0) begin errors++; $display("FAIL mul_we_width got=%b exp=0", bus.we_out); end
    checks++; if (bus.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_hold got=%h exp=ffffffeb", bus.result); end
  endtask

  task automatic test_mulh;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, r, rd, we, lat);
    checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
    checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mulhu_latency got=%0d exp=%0d", lat, MUL_LAT); end
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, r, rd, we, lat);
    checks++; if (r !== 32'h0000_0000) begin errors++; $display("FAIL mulh got=%h exp=00000000", r); end
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, r, rd, we, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, r, rd, we, lat);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_min got=%h exp=40000000", r); end
  endtask

  task automatic test_div;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, r, rd, we, lat);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got=%h exp=fffffffd", r); end
    checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL div_latency got=%0d exp=%0d", lat, DIV_LAT); end
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, r, rd, we, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
    do_op(3'd5, 32'd100, 32'd7, 5'd7, 0, r, rd, we, lat);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu got=%h exp=0000000e", r); end
    do_op(3'd7, 32'd100, 32'd7, 5'd7, 0, r, rd, we, lat);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu got=%h exp=00000002", r); end
    do_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd8, 0, r, rd, we, lat);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL rem_negdivisor got=%h exp=00000001", r); end
    do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, r, rd, we, lat);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL divu_min got=%h exp=00000000", r); end
    checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL divu_min_latency got=%0d exp=%0d", lat, DIV_LAT); end
  endtask

  task automatic test_short;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd4, 32'h1234_5678, 32'd0, 5'd10, 0, r, rd, we, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0 got=%h exp=ffffffff", r); end
    checks++; if (lat != 1) begin errors++; $display("FAIL div0_latency got=%0d exp=1", lat); end
    do_op(3'd7, 32'h1234_5678, 32'd0, 5'd10, 0, r, rd, we, lat);
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL remu0 got=%h exp=12345678", r); end
    checks++; if (lat != 1) begin errors++; $display("FAIL remu0_latency got=%0d exp=1", lat); end
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, r, rd, we, lat);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got=%h exp=80000000", r); end
    checks++; if (lat != 1) begin errors++; $display("FAIL div_ovf_latency got=%0d exp=1", lat); end
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, r, rd, we, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
    checks++; if (lat != 1) begin errors++; $display("FAIL rem_ovf_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 5'd11) begin errors++; $display("FAIL rem_ovf_rd got=%0d exp=11", rd); end
  endtask

  task automatic test_abort;
    logic [31:0] r; logic [4:0] rd; logic we; int lat; logic seen;
    bus.start = 1'b1; bus.op = 3'd5; bus.rs1_val = 32'hFFFF_FFFF; bus.rs2_val = 32'd3; bus.rd_in = 5'd12;
    @(posedge CLK);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", bus.busy); end
    reset = 1'b1;
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.done !== 1'b0 || bus.we_out !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_write got=%b exp=0", seen); end
    do_op(3'd5, 32'd9, 32'd3, 5'd13, 0, r, rd, we, lat);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL post_abort_divu got=%h exp=00000003", r); end
    checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL post_abort_latency got=%0d exp=%0d", lat, DIV_LAT); end
  endtask

  task automatic test_ignore_start;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd5, 32'd1000, 32'd10, 5'd14, 5, r, rd, we, lat);
    checks++; if (r !== 32'd100) begin errors++; $display("FAIL ignore_busy got=%h exp=00000064", r); end
    checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL ignore_busy_latency got=%0d exp=%0d", lat, DIV_LAT); end
    do_op(3'd5, 32'd1000, 32'd10, 5'd14, 32, r, rd, we, lat);
    checks++; if (r !== 32'd100) begin errors++; $display("FAIL ignore_done got=%h exp=00000064", r); end
    checks++; if (rd !== 5'd14) begin errors++; $display("FAIL ignore_done_rd got=%0d exp=14", rd); end
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_done_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_rd0;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd7, 32'd100, 32'd7, 5'd0, 0, r, rd, we, lat);
    checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL rd0_done got=%0d exp=%0d", lat, DIV_LAT); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rd0_we got=%b exp=0", we); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL rd0_result got=%h exp=00000002", r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd5, 32'd50, 32'd5, 5'd15, 0, r, rd, we, lat);
    do_op(3'd7, 32'd53, 32'd5, 5'd16, 0, r, rd, we, lat);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL b2b_result got=%h exp=00000003", r); end
    checks++; if (rd !== 5'd16) begin errors++; $display("FAIL b2b_rd got=%0d exp=16", rd); end
    checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, DIV_LAT); end
  endtask

`ifdef MULDIV_FAST_MUL_EN
  task automatic test_fast_mul;
    logic [31:0] r; logic [4:0] rd; logic we; int lat;
    do_op(3'd0, 32'd6, 32'd7, 5'd17, 0, r, rd, we, lat);
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL fast_mul got=%h exp=0000002a", r); end
    checks++; if (lat != 1) begin errors++; $display("FAIL fast_mul_latency got=%0d exp=1", lat); end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_short();
    test_abort();
    test_ignore_start();
    test_rd0();
    test_back_to_back();
`ifdef MULDIV_FAST_MUL_EN
    test_fast_mul();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
